// File: rtl/sequential_signed_36x18_divider.sv
// Multicycle signed 36/18 divider: radix-2 restoring division on magnitudes, fixed 20-cycle latency.
// Define DIVIDER_REMAINDER_EN to compute the signed remainder; otherwise remainder is tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for input_rdy; operands latched on accept
// S_SETUP  | form magnitudes and signs, range/zero prechecks
// S_DIVIDE | 18 restoring iterations, one quotient bit per cycle
// S_FIXUP  | apply signs, saturate, register outputs, pulse done
module sequential_signed_36x18_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_rdy,
  input  logic [35:0] dividend,
  input  logic [17:0] divisor,
  output logic [17:0] quotient,
  output logic [17:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DIVIDE,
    S_FIXUP
  } state_t;

  localparam logic [17:0] SAT_POS = 18'h1FFFF;
  localparam logic [17:0] SAT_NEG = 18'h20000;

  state_t      state_q;
  logic [35:0] dvd_q;
  logic [17:0] dvs_q;
  logic [17:0] dvs_mag_q;
  logic [18:0] pr_q;
  logic [17:0] low_q;
  logic [17:0] qmag_q;
  logic [4:0]  cnt_q;
  logic        res_neg_q;
  logic        dvd_neg_q;
  logic        ovf_pre_q;
  logic        dz_q;

  logic [17:0] quotient_q;
  logic        busy_q;
  logic        done_q;
  logic        overflow_q;
  logic        dz_out_q;

  logic [35:0] dvd_abs;
  logic [17:0] dvs_abs;
  logic [18:0] pr_shift;
  logic [18:0] pr_diff;
  logic        q_bit;
  logic [18:0] pr_d;
  logic [17:0] quotient_d;
  logic        overflow_d;

  always_comb begin
    dvd_abs = dvd_q[35] ? (36'd0 - dvd_q) : dvd_q;
    dvs_abs = dvs_q[17] ? (18'd0 - dvs_q) : dvs_q;
  end

  // Trial subtraction; the 19-bit shifted value holds one bit beyond the divisor width.
  always_comb begin
    pr_shift = 19'({pr_q, low_q[17]});
    pr_diff  = pr_shift - {1'b0, dvs_mag_q};
    q_bit    = (pr_shift >= {1'b0, dvs_mag_q});
    pr_d     = q_bit ? pr_diff : pr_shift;
  end

  always_comb begin
    quotient_d = res_neg_q ? (18'd0 - qmag_q) : qmag_q;
    overflow_d = 1'b0;
    if (dz_q) begin
      quotient_d = dvd_neg_q ? SAT_NEG : SAT_POS;
    end else if (ovf_pre_q ||
                 (res_neg_q ? (qmag_q > 18'd131072) : (qmag_q > 18'd131071))) begin
      quotient_d = res_neg_q ? SAT_NEG : SAT_POS;
      overflow_d = 1'b1;
    end
  end

`ifdef DIVIDER_REMAINDER_EN
  logic [17:0] remainder_q;
  logic [17:0] remainder_d;

  always_comb begin
    remainder_d = dvd_neg_q ? (18'd0 - pr_q[17:0]) : pr_q[17:0];
    if (dz_q || overflow_d) begin
      remainder_d = 18'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remainder_q <= 18'd0;
    end else if (state_q == S_FIXUP) begin
      remainder_q <= remainder_d;
    end
  end

  assign remainder = remainder_q;
`else
  assign remainder = 18'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dvd_q      <= 36'd0;
      dvs_q      <= 18'd0;
      dvs_mag_q  <= 18'd0;
      pr_q       <= 19'd0;
      low_q      <= 18'd0;
      qmag_q     <= 18'd0;
      cnt_q      <= 5'd0;
      res_neg_q  <= 1'b0;
      dvd_neg_q  <= 1'b0;
      ovf_pre_q  <= 1'b0;
      dz_q       <= 1'b0;
      quotient_q <= 18'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dz_out_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (input_rdy) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          dvd_neg_q <= dvd_q[35];
          res_neg_q <= dvd_q[35] ^ dvs_q[17];
          ovf_pre_q <= (dvd_abs >= {dvs_abs, 18'd0});
          dz_q      <= (dvs_q == 18'd0);
          dvs_mag_q <= dvs_abs;
          // Without a precheck overflow the upper half is already below |divisor|,
          // so it seeds the partial remainder and only 18 iterations are needed.
          pr_q      <= {1'b0, dvd_abs[35:18]};
          low_q     <= dvd_abs[17:0];
          qmag_q    <= 18'd0;
          cnt_q     <= 5'd0;
          state_q   <= S_DIVIDE;
        end
        S_DIVIDE: begin
          pr_q   <= pr_d;
          low_q  <= {low_q[16:0], 1'b0};
          qmag_q <= {qmag_q[16:0], q_bit};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd17) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          quotient_q <= quotient_d;
          overflow_q <= overflow_d;
          dz_out_q   <= dz_q;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dz_out_q;

endmodule
